// File: rtl/map_pkg.sv
// Shared definitions for the tile-map access sequencer: map geometry and fill-engine states.
package map_pkg;

    localparam int MAP_ROW_BITS  = 5;
    localparam int MAP_COL_BITS  = 5;
    localparam int MAP_TILE_BITS = 8;
    localparam int MAP_ROWS      = 1 << MAP_ROW_BITS;
    localparam int MAP_COLS      = 1 << MAP_COL_BITS;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'b00,
        FILL_RUN  = 2'b01,
        FILL_DONE = 2'b10
    } fill_state_e;

endpackage

// File: rtl/map_fill_walker.sv
// Rectangle walker for the fill engine: latches and clamps the rectangle, steps row-major
// offsets when not held, and produces the toroidally wrapped cell address plus a last-cell flag.
module map_fill_walker
    import map_pkg::*;
#(
    parameter int ROW_BITS = MAP_ROW_BITS,
    parameter int COL_BITS = MAP_COL_BITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                run,
    input  logic                hold,
    input  logic [ROW_BITS-1:0] start_row,
    input  logic [COL_BITS-1:0] start_col,
    input  logic [COL_BITS:0]   width,
    input  logic [ROW_BITS:0]   height,
    output logic [ROW_BITS-1:0] cell_row,
    output logic [COL_BITS-1:0] cell_col,
    output logic                last_cell,
    output logic                empty
);

    localparam logic [COL_BITS:0]   MAX_W = {1'b1, {COL_BITS{1'b0}}};
    localparam logic [ROW_BITS:0]   MAX_H = {1'b1, {ROW_BITS{1'b0}}};
    localparam logic [COL_BITS:0]   ONE_W = {{COL_BITS{1'b0}}, 1'b1};
    localparam logic [ROW_BITS:0]   ONE_H = {{ROW_BITS{1'b0}}, 1'b1};
    localparam logic [COL_BITS-1:0] ONE_C = {{(COL_BITS-1){1'b0}}, 1'b1};
    localparam logic [ROW_BITS-1:0] ONE_R = {{(ROW_BITS-1){1'b0}}, 1'b1};

    logic [ROW_BITS-1:0] base_row_r;
    logic [COL_BITS-1:0] base_col_r;
    logic [COL_BITS:0]   width_r;
    logic [ROW_BITS:0]   height_r;
    logic [ROW_BITS-1:0] r_r;
    logic [COL_BITS-1:0] c_r;
    logic                c_end_s;
    logic                r_end_s;

    // Address adders wrap naturally at the index width, giving the toroidal walk
    always_comb begin
        c_end_s   = ({1'b0, c_r} == (width_r - ONE_W));
        r_end_s   = ({1'b0, r_r} == (height_r - ONE_H));
        last_cell = c_end_s & r_end_s;
        empty     = (width == {(COL_BITS+1){1'b0}}) | (height == {(ROW_BITS+1){1'b0}});
        cell_row  = base_row_r + r_r;
        cell_col  = base_col_r + c_r;
    end

    // Rectangle latch (clamped so no cell is visited twice) and row-major offset counters
    always_ff @(posedge clock) begin
        if (reset) begin
            base_row_r <= {ROW_BITS{1'b0}};
            base_col_r <= {COL_BITS{1'b0}};
            width_r    <= {(COL_BITS+1){1'b0}};
            height_r   <= {(ROW_BITS+1){1'b0}};
            r_r        <= {ROW_BITS{1'b0}};
            c_r        <= {COL_BITS{1'b0}};
        end else if (load) begin
            base_row_r <= start_row;
            base_col_r <= start_col;
            width_r    <= (width > MAX_W) ? MAX_W : width;
            height_r   <= (height > MAX_H) ? MAX_H : height;
            r_r        <= {ROW_BITS{1'b0}};
            c_r        <= {COL_BITS{1'b0}};
        end else if (run && !hold) begin
            if (c_end_s) begin
                c_r <= {COL_BITS{1'b0}};
                r_r <= r_r + ONE_R;
            end else begin
                c_r <= c_r + ONE_C;
            end
        end
    end

endmodule

// File: rtl/map_access_sequencer.sv
// Owns the CPU-side port of the tile map RAM, arbitrating CPU accesses (strict priority) against
// the rectangle-fill engine. Optional MAP_SEQ_FILL_INCR_EN adds an incrementing-tile fill mode.
module map_access_sequencer
    import map_pkg::*;
#(
    parameter int ROW_BITS  = MAP_ROW_BITS,
    parameter int COL_BITS  = MAP_COL_BITS,
    parameter int TILE_BITS = MAP_TILE_BITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_write,
    input  logic [ROW_BITS-1:0]  cpu_row,
    input  logic [COL_BITS-1:0]  cpu_col,
    input  logic [TILE_BITS-1:0] cpu_data_in,
    output logic [TILE_BITS-1:0] cpu_data_out,
    output logic                 cpu_ack,
    input  logic                 fill_start,
    input  logic [ROW_BITS-1:0]  fill_row,
    input  logic [COL_BITS-1:0]  fill_col,
    input  logic [COL_BITS:0]    fill_width,
    input  logic [ROW_BITS:0]    fill_height,
    input  logic [TILE_BITS-1:0] fill_tile,
`ifdef MAP_SEQ_FILL_INCR_EN
    input  logic                 fill_incr,
`endif
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 map_cs,
    output logic                 map_read,
    output logic                 map_write,
    output logic [ROW_BITS-1:0]  map_row,
    output logic [COL_BITS-1:0]  map_col,
    output logic [TILE_BITS-1:0] map_data_out,
    input  logic [TILE_BITS-1:0] map_data_in
);

    fill_state_e          state_r;
    fill_state_e          state_s;
    logic                 pend_r;
    logic                 rd_pend_r;
    logic                 accept_s;
    logic                 fill_wr_s;
    logic                 walk_load_s;
    logic                 walk_run_s;
    logic                 last_s;
    logic                 empty_s;
    logic [ROW_BITS-1:0]  cell_row_s;
    logic [COL_BITS-1:0]  cell_col_s;
    logic [TILE_BITS-1:0] tile_r;

    map_fill_walker #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS)
    ) u_walker (
        .clock     (clock),
        .reset     (reset),
        .load      (walk_load_s),
        .run       (walk_run_s),
        .hold      (accept_s),
        .start_row (fill_row),
        .start_col (fill_col),
        .width     (fill_width),
        .height    (fill_height),
        .cell_row  (cell_row_s),
        .cell_col  (cell_col_s),
        .last_cell (last_s),
        .empty     (empty_s)
    );

    // Arbitration and fill next-state; a pending ack blocks re-accepting the same held request
    always_comb begin
        accept_s    = cpu_req & ~pend_r;
        walk_run_s  = (state_r == FILL_RUN);
        fill_wr_s   = 1'b0;
        walk_load_s = 1'b0;
        state_s     = state_r;
        case (state_r)
            FILL_IDLE: begin
                if (fill_start) begin
                    walk_load_s = 1'b1;
                    if (empty_s) begin
                        state_s = FILL_DONE;
                    end else begin
                        state_s = FILL_RUN;
                    end
                end else begin
                    state_s = FILL_IDLE;
                end
            end
            FILL_RUN: begin
                if (!accept_s) begin
                    fill_wr_s = 1'b1;
                    if (last_s) begin
                        state_s = FILL_DONE;
                    end else begin
                        state_s = FILL_RUN;
                    end
                end else begin
                    state_s = FILL_RUN;
                end
            end
            FILL_DONE: state_s = FILL_IDLE;
            default:   state_s = FILL_IDLE;
        endcase
    end

    // Registered map port, CPU handshake and fill status
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= FILL_IDLE;
            pend_r       <= 1'b0;
            rd_pend_r    <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_data_out <= {TILE_BITS{1'b0}};
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
            map_cs       <= 1'b0;
            map_read     <= 1'b0;
            map_write    <= 1'b0;
            map_row      <= {ROW_BITS{1'b0}};
            map_col      <= {COL_BITS{1'b0}};
            map_data_out <= {TILE_BITS{1'b0}};
        end else begin
            state_r   <= state_s;
            pend_r    <= accept_s;
            rd_pend_r <= accept_s & ~cpu_write;
            cpu_ack   <= pend_r;
            if (rd_pend_r) begin
                cpu_data_out <= map_data_in;
            end
            // Busy stays up through the last-write cycle so it drops as done rises
            fill_busy <= (state_s == FILL_RUN) | (state_r == FILL_RUN);
            fill_done <= (state_r == FILL_DONE);
            if (accept_s) begin
                map_cs       <= 1'b1;
                map_read     <= ~cpu_write;
                map_write    <= cpu_write;
                map_row      <= cpu_row;
                map_col      <= cpu_col;
                map_data_out <= cpu_data_in;
            end else if (fill_wr_s) begin
                map_cs       <= 1'b1;
                map_read     <= 1'b0;
                map_write    <= 1'b1;
                map_row      <= cell_row_s;
                map_col      <= cell_col_s;
                map_data_out <= tile_r;
            end else begin
                map_cs       <= 1'b0;
                map_read     <= 1'b0;
                map_write    <= 1'b0;
            end
        end
    end

`ifdef MAP_SEQ_FILL_INCR_EN
    localparam logic [TILE_BITS-1:0] TILE_ONE = {{(TILE_BITS-1){1'b0}}, 1'b1};
    logic incr_r;

    // Fill tile source; in increment mode it steps after every fill write
    always_ff @(posedge clock) begin
        if (reset) begin
            tile_r <= {TILE_BITS{1'b0}};
            incr_r <= 1'b0;
        end else if (walk_load_s) begin
            tile_r <= fill_tile;
            incr_r <= fill_incr;
        end else if (fill_wr_s && incr_r) begin
            tile_r <= tile_r + TILE_ONE;
        end
    end
`else
    // Fill tile source, constant for the whole rectangle
    always_ff @(posedge clock) begin
        if (reset) begin
            tile_r <= {TILE_BITS{1'b0}};
        end else if (walk_load_s) begin
            tile_r <= fill_tile;
        end
    end
`endif

endmodule

// File: tb/tb_map_access_sequencer.sv
// Self-checking bench for map_access_sequencer with a behavioural RAM and a rectangle-order model.
module tb_map_access_sequencer;

    localparam int NR = 32;
    localparam int NC = 32;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_write;
    logic [4:0] cpu_row, cpu_col;
    logic [7:0] cpu_data_in, cpu_data_out;
    logic       cpu_ack;
    logic       fill_start;
    logic [4:0] fill_row, fill_col;
    logic [5:0] fill_width, fill_height;
    logic [7:0] fill_tile;
    logic       fill_incr;
    logic       fill_busy, fill_done;
    logic       map_cs, map_read, map_write;
    logic [4:0] map_row, map_col;
    logic [7:0] map_data_out, map_data_in;

    always #5 clock = ~clock;

    map_access_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_write    (cpu_write),
        .cpu_row      (cpu_row),
        .cpu_col      (cpu_col),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_ack      (cpu_ack),
        .fill_start   (fill_start),
        .fill_row     (fill_row),
        .fill_col     (fill_col),
        .fill_width   (fill_width),
        .fill_height  (fill_height),
        .fill_tile    (fill_tile),
`ifdef MAP_SEQ_FILL_INCR_EN
        .fill_incr    (fill_incr),
`endif
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .map_cs       (map_cs),
        .map_read     (map_read),
        .map_write    (map_write),
        .map_row      (map_row),
        .map_col      (map_col),
        .map_data_out (map_data_out),
        .map_data_in  (map_data_in)
    );

    // RAM b-port: acts on the falling edge after the registered request
    logic       ram_clear;
    logic [7:0] ram [NR][NC];
    logic [7:0] ram_q;
    assign map_data_in = ram_q;

    always @(negedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < NR; i++)
                for (int j = 0; j < NC; j++)
                    ram[i][j] <= 8'h00;
            ram_q <= 8'h00;
        end else if (map_cs) begin
            if (map_write) ram[map_row][map_col] <= map_data_out;
            if (map_read)  ram_q <= ram[map_row][map_col];
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_mem [NR][NC];
    logic [7:0] last_rd;
    int         er [1024];
    int         ec [1024];
    logic [7:0] ed [1024];
    int         pos [NR][NC];

    function automatic logic [31:0] out_vec();
        return {map_cs, map_read, map_write, map_row, map_col, map_data_out,
                cpu_ack, cpu_data_out, fill_busy, fill_done};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected write order: row-major over the clamped rectangle, wrapping at the map edges
    task automatic build_model(input int row, input int col, input int w, input int h,
                               input logic [7:0] tile, input bit incr, output int n);
        int wc, hc;
        wc = (w > NC) ? NC : w;
        hc = (h > NR) ? NR : h;
        n  = wc * hc;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NC; j++)
                pos[i][j] = -1;
        for (int r = 0; r < hc; r++) begin
            for (int c = 0; c < wc; c++) begin
                int k;
                k = r * wc + c;
                er[k] = (row + r) % NR;
                ec[k] = (col + c) % NC;
                ed[k] = incr ? 8'((int'(tile) + k) % 256) : tile;
                pos[er[k]][ec[k]] = k;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ram_clear = 1'b1;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_row = 5'd0; cpu_col = 5'd0; cpu_data_in = 8'h00;
        fill_start = 1'b0; fill_row = 5'd0; fill_col = 5'd0; fill_width = 6'd0;
        fill_height = 6'd0; fill_tile = 8'h00; fill_incr = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (out_vec() !== 32'h0)
            begin errors++; $display("FAIL reset_outputs got %h want %h", out_vec(), 32'h0); end
        reset = 1'b0; ram_clear = 1'b0;
        tick();
        checks++;
        if ({map_cs, map_read, map_write, fill_busy, fill_done, cpu_ack} !== 6'b0)
            begin errors++; $display("FAIL reset_release got %b want 000000",
                {map_cs, map_read, map_write, fill_busy, fill_done, cpu_ack}); end
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NC; j++)
                exp_mem[i][j] = 8'h00;
        last_rd = 8'h00;
    endtask

    task automatic cpu_access(input logic wr, input logic [4:0] r, input logic [4:0] c,
                              input logic [7:0] d);
        cpu_req = 1'b1; cpu_write = wr; cpu_row = r; cpu_col = c; cpu_data_in = d;
        tick();
        checks++;
        if ({map_cs, map_read, map_write, map_row, map_col} !== {1'b1, ~wr, wr, r, c} ||
            (wr && map_data_out !== d) || cpu_ack !== 1'b0)
            begin errors++; $display("FAIL cpu_issue got cs%b rd%b wr%b r%0d c%0d d%h ack%b want cs1 rd%b wr%b r%0d c%0d d%h ack0",
                map_cs, map_read, map_write, map_row, map_col, map_data_out, cpu_ack, ~wr, wr, r, c, d); end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || map_cs !== 1'b0)
            begin errors++; $display("FAIL cpu_ack got ack%b cs%b want ack1 cs0", cpu_ack, map_cs); end
        if (!wr) last_rd = exp_mem[r][c];
        checks++;
        if (cpu_data_out !== last_rd)
            begin errors++; $display("FAIL cpu_data_out got %h want %h", cpu_data_out, last_rd); end
        cpu_req = 1'b0;
        if (wr) exp_mem[r][c] = d;
        tick();
        checks++;
        if (cpu_ack !== 1'b0)
            begin errors++; $display("FAIL cpu_ack_pulse got %b want 0", cpu_ack); end
    endtask

    task automatic test_cpu_rw();
        cpu_access(1'b1, 5'd3, 5'd7, 8'h42);
        cpu_access(1'b0, 5'd3, 5'd7, 8'h00);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] r, c;
            r = 5'($urandom); c = 5'($urandom);
            cpu_access(1'b1, r, c, 8'($urandom));
            cpu_access(1'b0, 5'($urandom), 5'($urandom), 8'h00);
            cpu_access(1'b0, r, c, 8'h00);
        end
    endtask

    task automatic fill_run(input int row, input int col, input int w, input int h,
                            input logic [7:0] tile, input bit incr, input bit cpu_on, input bit spam);
        int n, nwr, t, done_at, gaps, busy_bad, idx;
        bit acc_prev;
        logic exp_busy;
        logic [7:0] rd_exp;
        build_model(row, col, w, h, tile, incr, n);
        exp_busy = (n > 0);
        fill_row = 5'(row); fill_col = 5'(col); fill_width = 6'(w); fill_height = 6'(h);
        fill_tile = tile; fill_incr = incr; fill_start = 1'b1;
        tick();
        t = 1;
        fill_start = 1'b0;
        checks++;
        if (fill_busy !== exp_busy || map_cs !== 1'b0 || fill_done !== 1'b0)
            begin errors++; $display("FAIL fill_start_cycle got busy%b cs%b done%b want busy%b cs0 done0",
                fill_busy, map_cs, fill_done, exp_busy); end
        cpu_req = cpu_on; cpu_write = 1'b0; cpu_row = 5'($urandom); cpu_col = 5'($urandom);
        nwr = 0; done_at = 0; gaps = 0; busy_bad = 0; acc_prev = 1'b0; rd_exp = 8'h00;
        while (t < 5000) begin
            tick();
            t++;
            checks++;
            if (cpu_ack !== acc_prev)
                begin errors++; $display("FAIL fill_cpu_ack t%0d got %b want %b", t, cpu_ack, acc_prev); end
            if (acc_prev) begin
                checks++;
                if (cpu_data_out !== rd_exp)
                    begin errors++; $display("FAIL fill_cpu_rdata got %h want %h", cpu_data_out, rd_exp); end
                last_rd = rd_exp;
            end
            acc_prev = map_cs && map_read;
            if (acc_prev) begin
                checks++;
                if ({map_row, map_col, map_write} !== {cpu_row, cpu_col, 1'b0})
                    begin errors++; $display("FAIL fill_cpu_addr got r%0d c%0d w%b want r%0d c%0d w0",
                        map_row, map_col, map_write, cpu_row, cpu_col); end
                idx = pos[cpu_row][cpu_col];
                rd_exp = (idx >= 0 && idx < nwr) ? ed[idx] : exp_mem[cpu_row][cpu_col];
            end
            if (map_cs && map_write) begin
                checks++;
                if (nwr >= n)
                    begin errors++; $display("FAIL fill_extra_write got r%0d c%0d want none", map_row, map_col); end
                else if ({map_row, map_col, map_data_out} !== {5'(er[nwr]), 5'(ec[nwr]), ed[nwr]})
                    begin errors++; $display("FAIL fill_write[%0d] got r%0d c%0d d%h want r%0d c%0d d%h",
                        nwr, map_row, map_col, map_data_out, er[nwr], ec[nwr], ed[nwr]); end
                nwr++;
            end
            if (done_at == 0) begin
                if (fill_done) begin
                    done_at = t;
                    cpu_req = 1'b0;
                    checks++;
                    if (fill_busy !== 1'b0)
                        begin errors++; $display("FAIL fill_done_busy got %b want 0", fill_busy); end
                end else begin
                    if (fill_busy !== exp_busy) busy_bad++;
                    if (exp_busy && !map_cs) gaps++;
                end
            end else if (t == done_at + 1) begin
                checks++;
                if (fill_done !== 1'b0 || fill_busy !== 1'b0)
                    begin errors++; $display("FAIL fill_done_pulse got done%b busy%b want 0 0", fill_done, fill_busy); end
            end
            if (cpu_ack) begin cpu_row = 5'($urandom); cpu_col = 5'($urandom); end
            if (spam && done_at == 0) begin
                fill_start = ($urandom_range(0, 3) == 0);
                fill_row = 5'($urandom); fill_col = 5'($urandom);
                fill_width = 6'($urandom); fill_height = 6'($urandom); fill_tile = 8'($urandom);
            end else begin
                fill_start = 1'b0;
            end
            if (done_at != 0 && t > done_at && !acc_prev) break;
        end
        fill_start = 1'b0;
        cpu_req = 1'b0;
        checks++;
        if (done_at == 0)
            begin errors++; $display("FAIL fill_timeout got no done want done"); end
        checks++;
        if (nwr != n)
            begin errors++; $display("FAIL fill_count got %0d want %0d", nwr, n); end
        checks++;
        if (gaps != 0 || busy_bad != 0)
            begin errors++; $display("FAIL fill_stall got gaps%0d busy_bad%0d want 0 0", gaps, busy_bad); end
        if (!cpu_on) begin
            checks++;
            if (done_at != n + 2)
                begin errors++; $display("FAIL fill_done_time got %0d want %0d", done_at, n + 2); end
        end
        for (int k = 0; k < n; k++) exp_mem[er[k]][ec[k]] = ed[k];
    endtask

    task automatic test_reset_mid_fill();
        int n, nwr, bad;
        logic [7:0] tile;
        tile = 8'($urandom);
        build_model(0, 0, 32, 32, tile, 1'b0, n);
        fill_row = 5'd0; fill_col = 5'd0; fill_width = 6'd32; fill_height = 6'd32;
        fill_tile = tile; fill_incr = 1'b0; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        nwr = 0;
        for (int i = 0; i < 100 && nwr < 5; i++) begin
            tick();
            if (map_cs && map_write) nwr++;
        end
        checks++;
        if (nwr != 5)
            begin errors++; $display("FAIL midfill_writes got %0d want 5", nwr); end
        reset = 1'b1; cpu_req = 1'b1; cpu_write = 1'b0;
        tick();
        checks++;
        if (out_vec() !== 32'h0)
            begin errors++; $display("FAIL midfill_reset got %h want %h", out_vec(), 32'h0); end
        reset = 1'b0; cpu_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (map_cs || cpu_ack || fill_busy || fill_done) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL midfill_quiet got %0d active cycles want 0", bad); end
        last_rd = 8'h00;
        for (int k = 0; k < 5; k++) exp_mem[er[k]][ec[k]] = ed[k];
        cpu_access(1'b0, 5'd0, 5'd4, 8'h00);
        cpu_access(1'b0, 5'd0, 5'd5, 8'h00);
    endtask

    task automatic test_fill_random();
        for (int i = 0; i < 6; i++) begin
            bit incr;
`ifdef MAP_SEQ_FILL_INCR_EN
            incr = 1'($urandom);
`else
            incr = 1'b0;
`endif
            fill_run($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 40),
                     $urandom_range(0, 40), 8'($urandom), incr, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_readback();
        for (int i = 0; i < 8; i++)
            cpu_access(1'b0, 5'($urandom), 5'($urandom), 8'h00);
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        fill_run(0, 0, 4, 2, 8'h11, 1'b0, 1'b0, 1'b0);
        fill_run(30, 30, 4, 3, 8'h5A, 1'b0, 1'b0, 1'b0);
        fill_run(0, 0, 32, 32, 8'hC3, 1'b0, 1'b1, 1'b0);
        fill_run(7, 9, 0, 5, 8'h77, 1'b0, 1'b0, 1'b0);
        fill_run(7, 9, 6, 0, 8'h78, 1'b0, 1'b0, 1'b1);
        fill_run(3, 17, 63, 33, 8'h2D, 1'b0, 1'b1, 1'b1);
        test_reset_mid_fill();
`ifdef MAP_SEQ_FILL_INCR_EN
        fill_run(5, 5, 3, 2, 8'hFE, 1'b1, 1'b0, 1'b0);
`endif
        test_fill_random();
        test_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_access_sequencer.md
Name: map_access_sequencer

Overview:
- Owns the CPU-side (b) port of the 32x32 tile map RAM.
- Arbitrates that port between the CPU bus and a built-in rectangle-fill engine.
- The fill engine lets software clear or paint map regions without issuing one CPU write per tile.
- The display-side (a) port is untouched.

Parameters:
- ROW_BITS, 5, map row index width (2^ROW_BITS rows)
- COL_BITS, 5, map column index width (2^COL_BITS columns)
- TILE_BITS, 8, tile code width

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU map access request (level)
- cpu_write  in  1  1 = write, 0 = read
- cpu_row  in  ROW_BITS  CPU row index
- cpu_col  in  COL_BITS  CPU column index
- cpu_data_in  in  TILE_BITS  CPU write data
- cpu_data_out  out  TILE_BITS  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle access-complete pulse
- fill_start  in  1  start fill command (sampled in IDLE only)
- fill_row  in  ROW_BITS  top-left row
- fill_col  in  COL_BITS  top-left column
- fill_width  in  COL_BITS+1  columns to fill
- fill_height  in  ROW_BITS+1  rows to fill
- fill_tile  in  TILE_BITS  tile code to write
- fill_busy  out  1  engine active
- fill_done  out  1  one-cycle pulse at completion
- map_cs  out  1  to RAM b_cs
- map_read  out  1  to RAM b_read
- map_write  out  1  to RAM b_write
- map_row  out  ROW_BITS  to RAM b_row_index
- map_col  out  COL_BITS  to RAM b_col_index
- map_data_out  out  TILE_BITS  to RAM b_in
- map_data_in  in  TILE_BITS  from RAM b_out

Behaviour:
Map outputs
- All map_* outputs are registered on rising edge.
- The RAM acts on the following falling edge, so a read result is on map_data_in by the next rising edge.

Reset
- Returns to IDLE.
- All outputs are 0: map_cs, map_read, map_write, map_row, map_col, map_data_out, cpu_ack, cpu_data_out, fill_busy, fill_done.
- A fill in progress is abandoned mid-rectangle; cells already written stay written.
- An un-acked CPU access is dropped; no ack is issued.

CPU access
- Accepted on any rising edge where cpu_req=1 and cpu_ack is not being driven high that cycle.
- Cycle N (accept): registers map_cs=1, map_read=~cpu_write, map_write=cpu_write, row, col and data.
- Cycle N+1: cpu_ack=1. For reads, cpu_data_out is captured from map_data_in and held until the next read ack.
- Maximum rate is one access per 2 cycles.
- CPU holds address and data stable until ack.

Fill engine states
- IDLE:
  - On fill_start: latch all fill_* inputs, reset the offset counters to r=0, c=0.
  - If width==0 or height==0, go to DONE.
  - Otherwise go to RUN and set fill_busy=1.
- RUN:
  - Each cycle with no CPU access accepted, issue a write (map_cs=1, map_write=1) at row (fill_row+r) mod 2^ROW_BITS, col (fill_col+c) mod 2^COL_BITS.
  - Walk is row-major: c increments; at c==width-1, c returns to 0 and r increments.
  - After the cell (height-1, width-1) is written, go to DONE.
- DONE: fill_done=1 for one cycle, fill_busy=0, return to IDLE.

Arbitration and limits
- The CPU has strict priority. In a cycle where a CPU access is accepted, the engine holds its counters and issues nothing.
- The CPU is never starved; the fill can be stalled indefinitely.
- Width and height above 2^COL_BITS / 2^ROW_BITS are clamped to the maximum, so no cell is written twice.
- A rectangle that crosses an edge wraps toroidally.
- fill_start while busy is ignored.
- Write count is exactly min(w,32) * min(h,32).
- Idle cycles drive map_cs=0, map_read=0, map_write=0.

Optional Feature:
- Macro: MAP_SEQ_FILL_INCR_EN.
- When defined:
  - Adds input port fill_incr (1 bit), latched at fill_start.
  - If fill_incr=1, the written tile starts at fill_tile and increments by 1 (mod 2^TILE_BITS) after each fill write, in row-major order.
  - If fill_incr=0, behaviour is identical to the base fill.
- When undefined: the port is absent and every cell receives fill_tile.

Decomposition:
- Shared package map_pkg:
  - MAP_ROW_BITS=5, MAP_COL_BITS=5, MAP_TILE_BITS=8.
  - Derived MAP_ROWS and MAP_COLS.
  - Fill state enum {FILL_IDLE, FILL_RUN, FILL_DONE}.
- One sub-module, map_fill_walker: holds the r/c offset counters with a hold input, the clamp logic, the wrap-around address adders and the last-cell flag.
- Arbitration and output registers stay in the top level.

Test Plan:
- Reset then CPU write (row 3, col 7, data 0x42), then CPU read (3,7) -> one map_write at (3,7) with 0x42; ack one cycle after each accept; read returns cpu_data_out=0x42.
- Fill at (0,0), w=4, h=2, tile 0x11, CPU idle -> 8 consecutive writes (0,0)..(0,3),(1,0)..(1,3); fill_done pulses the cycle after the last write; fill_busy high from the cycle after start until done.
- Fill at (30,30), w=4, h=3 -> writes cover rows 30,31,0 and cols 30,31,0,1 (12 writes); no out-of-range index.
- CPU read issued every 2 cycles during a 32x32 fill -> every CPU access is acked next cycle; fill stalls only on accept cycles; exactly 1024 fill writes, none duplicated.
- fill_start with w=0 -> no map_write; fill_done pulses 2 cycles after start. Reset asserted mid-fill after 5 writes -> all outputs 0 next cycle; no further writes.
- With MAP_SEQ_FILL_INCR_EN: fill w=3, h=2, tile 0xFE, incr=1 -> data sequence FE, FF, 00, 01, 02, 03.
